// File: rtl/bitop_pkg.sv
// bitop_pkg: shared opcode definitions for the streaming bitwise accumulator.
// The operator encoding is 3 bits wide. Codes 0..5 are defined operators.
// Codes 6 and 7 are reserved: the datapath treats them as PASS and flags them.
package bitop_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_XNOR = 3'd3,
    OP_NOT  = 3'd4,
    OP_PASS = 3'd5
  } op_e;

  localparam logic [2:0] OP_RSVD6 = 3'd6;
  localparam logic [2:0] OP_RSVD7 = 3'd7;

  // True for the two opcodes that have no defined operator.
  function automatic logic is_rsvd(input logic [2:0] op);
    return (op == OP_RSVD6) || (op == OP_RSVD7);
  endfunction

endpackage

// File: rtl/bitop_alu.sv
// bitop_alu: purely combinational per-beat operator.
// It computes y = f(op, a, b), where a is the running accumulator and b is the
// incoming word. The rsvd output flags an undefined opcode. For such an opcode
// y falls back to PASS (y = b), so a bad code still yields a defined result.
module bitop_alu
  import bitop_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             rsvd
);

  // Operator select; NOT ignores b, reserved codes behave as PASS.
  always_comb begin
    y = b;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_NOT:  y = ~a;
      OP_PASS: y = b;
      default: y = b;
    endcase
  end

  assign rsvd = is_rsvd(op);

endmodule

// File: rtl/bitop_stream_acc.sv
// bitop_stream_acc: folds a valid/ready burst of WIDTH-bit words into a single
// result using a per-beat bitwise operator. The result is returned together
// with a saturating beat count, an overflow flag and a reserved-opcode flag.
//
// Optional build macro: BITOP_REDUCE_EN
//   When it is defined, the out_all1/out_all0/out_par reduction flags are
//   computed and registered with the result.
//   When it is undefined, these ports are tied to 0 and no reduction logic
//   is built.
//
// Flow control: in_ready = !out_valid || out_ready. Every beat, last or not,
// stalls while a result sits unconsumed. This keeps the burst state
// trivially consistent with the single output register.
module bitop_stream_acc
  import bitop_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 255,
  localparam int CNT_W    = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_op,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             out_err,
  output logic             out_all1,
  output logic             out_all0,
  output logic             out_par
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_ACC  = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Open-burst state
  logic             state_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             ovf_reg;
  logic             err_reg;

  // Post-update values for the beat being accepted this cycle
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_next;
  logic             err_next;
  logic             cnt_at_max;

  // Output register
  logic             valid_reg;
  logic [WIDTH-1:0] data_reg;
  logic [CNT_W-1:0] count_reg;
  logic             ovf_out_reg;
  logic             err_out_reg;

  logic [WIDTH-1:0] alu_y;
  logic             alu_rsvd;
  logic             accept;
  logic             publish;

  assign in_ready = !valid_reg || out_ready;
  assign accept   = in_valid && in_ready;
  assign publish  = accept && in_last;

  bitop_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .op   (in_op),
    .a    (acc_reg),
    .b    (in_data),
    .y    (alu_y),
    .rsvd (alu_rsvd)
  );

  assign cnt_at_max = (cnt_reg == CNT_MAX);

  // The first beat of a burst loads the word as-is. Later beats fold the word
  // through the ALU, count with saturation and accumulate the sticky flags.
  always_comb begin
    acc_next = alu_y;
    cnt_next = cnt_reg;
    ovf_next = ovf_reg;
    err_next = err_reg | alu_rsvd;
    if (state_reg == ST_IDLE) begin
      acc_next = in_data;
      cnt_next = CNT_ONE;
      ovf_next = 1'b0;
      err_next = alu_rsvd;
    end else begin
      cnt_next = cnt_at_max ? cnt_reg : (cnt_reg + CNT_ONE);
      ovf_next = ovf_reg | cnt_at_max;
    end
  end

  // Burst FSM and accumulator. A publishing beat clears the state so that
  // the next burst starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else if (accept) begin
      if (in_last) begin
        state_reg <= ST_IDLE;
        acc_reg   <= '0;
        cnt_reg   <= '0;
        ovf_reg   <= 1'b0;
        err_reg   <= 1'b0;
      end else begin
        state_reg <= ST_ACC;
        acc_reg   <= acc_next;
        cnt_reg   <= cnt_next;
        ovf_reg   <= ovf_next;
        err_reg   <= err_next;
      end
    end
  end

  // Output register. It loads on publish and drops valid once the result is
  // taken with no replacement. It holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg   <= 1'b0;
      data_reg    <= '0;
      count_reg   <= '0;
      ovf_out_reg <= 1'b0;
      err_out_reg <= 1'b0;
    end else if (publish) begin
      valid_reg   <= 1'b1;
      data_reg    <= acc_next;
      count_reg   <= cnt_next;
      ovf_out_reg <= ovf_next;
      err_out_reg <= err_next;
    end else if (out_ready) begin
      valid_reg   <= 1'b0;
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign out_count = count_reg;
  assign out_ovf   = ovf_out_reg;
  assign out_err   = err_out_reg;

`ifdef BITOP_REDUCE_EN
  logic all1_reg;
  logic all0_reg;
  logic par_reg;

  // The reduction flags are taken from the word being published, so they stay
  // aligned with out_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      all1_reg <= 1'b0;
      all0_reg <= 1'b0;
      par_reg  <= 1'b0;
    end else if (publish) begin
      all1_reg <= &acc_next;
      all0_reg <= ~|acc_next;
      par_reg  <= ^acc_next;
    end
  end

  assign out_all1 = all1_reg;
  assign out_all0 = all0_reg;
  assign out_par  = par_reg;
`else
  assign out_all1 = 1'b0;
  assign out_all0 = 1'b0;
  assign out_par  = 1'b0;
`endif

endmodule
